// File: rtl/spi_encoder.sv
// spi_encoder: SPI mode-0 byte transmitter, MSB first. CSN stays low
// across back-to-back bytes and rises only when no byte is offered at
// a byte boundary. Every output is taken straight from a flop.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   tx_data/valid/ready   byte stream in (handshake when valid && ready)
//   sclk, mosi, csn       SPI bus out (sclk idles low, csn active low)
//   busy                  high whenever the FSM is not idle
//   byte_done             one-cycle pulse after each byte's last SCLK high phase
module spi_encoder #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_IDLE     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sclk,
    output logic       mosi,
    output logic       csn,
    output logic       busy,
    output logic       byte_done
);

    localparam int MAX_A  = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int MAX_PH = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
    // Phase counts 0..MAX_PH-1 and is cleared on every state change.
    localparam int PW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    localparam logic [PW-1:0] HP_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] SU_LAST = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] ID_LAST = PW'(CS_IDLE - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_ready_q, tx_ready_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          csn_q, csn_d;
    logic          busy_q, busy_d;
    logic          byte_done_q, byte_done_d;

    logic          hs;
    logic          active;
    logic          last_high;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;

        // tx_ready_q is only ever high in IDLE or at the byte boundary.
        hs        = tx_valid && tx_ready_q;
        last_high = (state_q == ST_HIGH) && (bit_cnt_q == 3'd7) &&
                    (phase_q == HP_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_SETUP;
                    shreg_d   = tx_data;
                    bit_cnt_d = 3'd0;
                    phase_d   = PH_ZERO;
                end
            end
            ST_SETUP: begin
                if (phase_q == SU_LAST) begin
                    state_d = ST_HIGH;
                    phase_d = PH_ZERO;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_HIGH: begin
                if (phase_q == HP_LAST) begin
                    phase_d = PH_ZERO;
                    if (bit_cnt_q != 3'd7) begin
                        state_d   = ST_LOW;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                    end else if (hs) begin
                        // Back-to-back byte: no extra gap, CSN stays low.
                        state_d   = ST_LOW;
                        bit_cnt_d = 3'd0;
                        shreg_d   = tx_data;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_LOW: begin
                if (phase_q == HP_LAST) begin
                    state_d = ST_HIGH;
                    phase_d = PH_ZERO;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_HOLD: begin
                if (phase_q == HP_LAST) begin
                    state_d = ST_GAP;
                    phase_d = PH_ZERO;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_GAP: begin
                if (phase_q == ID_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = PH_ZERO;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_ZERO;
            end
        endcase

        // Outputs are decoded from the next state so they come out of flops
        // aligned with the state they belong to.
        active      = (state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                      (state_d == ST_LOW)   || (state_d == ST_HOLD);
        csn_d       = !active;
        sclk_d      = (state_d == ST_HIGH);
        mosi_d      = active ? shreg_d[7] : 1'b0;
        busy_d      = (state_d != ST_IDLE);
        tx_ready_d  = (state_d == ST_IDLE) ||
                      ((state_d == ST_HIGH) && (bit_cnt_d == 3'd7) &&
                       (phase_d == HP_LAST));
        byte_done_d = last_high;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ZERO;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            tx_ready_q  <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            csn_q       <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            tx_ready_q  <= tx_ready_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            csn_q       <= csn_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign tx_ready  = tx_ready_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign csn       = csn_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule

// File: tb/tb_spi_encoder.sv
// tb_spi_encoder: two spi_encoder instances (default timing and fastest
// timing) checked cycle by cycle against an expected-waveform schedule.
module tb_spi_encoder;

    localparam int NCYC = 16384;
    localparam logic [5:0] IDLE_V = 6'b100100;
    localparam logic [5:0] RST_V  = 6'b100000;
    localparam logic [5:0] GAP_V  = 6'b100010;

    logic       clk;
    logic [1:0] rst_v;
    logic [1:0] tx_valid_v;
    logic [7:0] tx_data_v [2];
    logic       rdy_w  [2];
    logic       sclk_w [2];
    logic       mosi_w [2];
    logic       csn_w  [2];
    logic       busy_w [2];
    logic       bd_w   [2];

    spi_encoder u_dut0 (
        .clk       (clk),
        .rst       (rst_v[0]),
        .tx_data   (tx_data_v[0]),
        .tx_valid  (tx_valid_v[0]),
        .tx_ready  (rdy_w[0]),
        .sclk      (sclk_w[0]),
        .mosi      (mosi_w[0]),
        .csn       (csn_w[0]),
        .busy      (busy_w[0]),
        .byte_done (bd_w[0])
    );

    spi_encoder #(
        .HALF_PERIOD (1),
        .CS_SETUP    (1),
        .CS_IDLE     (1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst_v[1]),
        .tx_data   (tx_data_v[1]),
        .tx_valid  (tx_valid_v[1]),
        .tx_ready  (rdy_w[1]),
        .sclk      (sclk_w[1]),
        .mosi      (mosi_w[1]),
        .csn       (csn_w[1]),
        .busy      (busy_w[1]),
        .byte_done (bd_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic int hp(int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int sp(int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int ip(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Expected {csn, sclk, mosi, tx_ready, busy, byte_done} per cycle.
    logic [5:0] exp_w [2][NCYC];
    logic [7:0] sbuf [2][256];
    int  wp [2], rp [2], hi [2], bnd [2];
    int  hs_cnt [2], last_hs [2], last_bd [2], bdc [2];
    int  rises [2], falls [2], dec_cnt [2], nb [2];
    int  hirun [2], hirun_cur [2];
    bit  armed [2], psclk [2], pcsn [2];
    logic [7:0] sh [2], last_dec [2];
    logic [5:0] obs;

    task automatic put(int i, int k, logic [5:0] v);
        if (k >= 0 && k < NCYC) exp_w[i][k] = v;
    endtask

    task automatic set_bit(int i, int k, int b);
        if (k >= 0 && k < NCYC) exp_w[i][k][b] = 1'b1;
    endtask

    // Lays out the waveform of one byte accepted at cycle t, either opening
    // a frame or continuing one at the byte boundary t.
    task automatic sched(int i, int t, logic [7:0] d, bit cont);
        int h, r0, b;
        h = hp(i);
        if (cont) begin
            for (int k = 1; k <= h; k++) put(i, t + k, {2'b00, d[7], 3'b010});
            r0 = t + 1 + h;
        end else begin
            for (int k = 1; k <= sp(i); k++) put(i, t + k, {2'b00, d[7], 3'b010});
            r0 = t + sp(i) + 1;
        end
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < h; j++)
                put(i, r0 + 2 * h * k + j, {2'b01, d[7 - k], 3'b010});
            if (k < 7)
                for (int j = 0; j < h; j++)
                    put(i, r0 + 2 * h * k + h + j, {2'b00, d[6 - k], 3'b010});
        end
        b = r0 + 15 * h - 1;
        set_bit(i, b, 2);
        for (int j = 1; j <= h; j++) put(i, b + j, {2'b00, d[0], 3'b010});
        for (int j = 1; j <= ip(i); j++) put(i, b + h + j, GAP_V);
        set_bit(i, b + 1, 0);
        if (cont) set_bit(i, t + 1, 0);
        bnd[i] = b;
        hi[i]  = b + h + ip(i);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NCYC; k++) exp_w[i][k] = IDLE_V;
            bnd[i] = -1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            obs = {csn_w[i], sclk_w[i], mosi_w[i], rdy_w[i], busy_w[i], bd_w[i]};
            if (armed[i] && cyc < NCYC)
                chk(i == 0 ? "outs0" : "outs1", 32'(obs), 32'(exp_w[i][cyc]));
            if (armed[i]) begin
                if (csn_w[i]) begin
                    nb[i] = 0;
                    hirun_cur[i]++;
                end else begin
                    if (pcsn[i]) begin
                        falls[i]++;
                        hirun[i] = hirun_cur[i];
                    end
                    hirun_cur[i] = 0;
                    if (sclk_w[i] && !psclk[i]) begin
                        sh[i] = {sh[i][6:0], mosi_w[i]};
                        nb[i]++;
                        rises[i]++;
                        if (nb[i] == 8) begin
                            nb[i] = 0;
                            dec_cnt[i]++;
                            last_dec[i] = sh[i];
                            if (wp[i] != rp[i]) begin
                                chk("loop", 32'(sh[i]), 32'(sbuf[i][rp[i] % 256]));
                                rp[i]++;
                            end else begin
                                chk("loop_extra", 32'(wp[i] - rp[i]), 32'd1);
                            end
                        end
                    end
                end
                if (bd_w[i]) begin
                    bdc[i]++;
                    last_bd[i] = cyc;
                end
            end
            psclk[i] = sclk_w[i];
            pcsn[i]  = csn_w[i];

            if (rst_v[i]) begin
                for (int k = cyc + 1; k <= hi[i] && k < NCYC; k++)
                    exp_w[i][k] = IDLE_V;
                put(i, cyc + 1, RST_V);
                if (hi[i] < cyc + 1) hi[i] = cyc + 1;
                bnd[i]   = -1;
                rp[i]    = wp[i];
                armed[i] = 1'b1;
            end else if (armed[i] && cyc < NCYC && tx_valid_v[i] &&
                         exp_w[i][cyc][2]) begin
                sbuf[i][wp[i] % 256] = tx_data_v[i];
                wp[i]++;
                hs_cnt[i]++;
                last_hs[i] = cyc;
                sched(i, cyc, tx_data_v[i], cyc == bnd[i]);
            end
        end
    end

    task automatic offer(int i, logic [7:0] d);
        int h0;
        bit ok;
        h0 = hs_cnt[i];
        ok = 1'b0;
        tx_valid_v[i] = 1'b1;
        tx_data_v[i]  = d;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (hs_cnt[i] != h0) ok = 1'b1;
        end
        chk("hs_wait", 32'(ok), 32'd1);
    endtask

    task automatic idle_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r0s, b0s, d0s, f0s, h0s, t0s;
    bit got4;

    initial begin
        rst_v        = 2'b11;
        tx_valid_v   = 2'b00;
        tx_data_v[0] = 8'h00;
        tx_data_v[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 2'b00;
        idle_cycles(4);

        // Single byte on default timing.
        r0s = rises[0]; b0s = bdc[0]; d0s = dec_cnt[0]; f0s = falls[0];
        offer(0, 8'hA5);
        tx_valid_v[0] = 1'b0;
        t0s = last_hs[0];
        idle_cycles(90);
        chk("single_bd_lat", 32'(last_bd[0] - t0s), 32'd63);
        chk("single_rises", 32'(rises[0] - r0s), 32'd8);
        chk("single_bd", 32'(bdc[0] - b0s), 32'd1);
        chk("single_dec", 32'(dec_cnt[0] - d0s), 32'd1);
        chk("single_val", 32'(last_dec[0]), 32'hA5);
        chk("single_frames", 32'(falls[0] - f0s), 32'd1);

        // Back-to-back bytes in one frame.
        r0s = rises[0]; b0s = bdc[0]; d0s = dec_cnt[0]; f0s = falls[0];
        offer(0, 8'h3C);
        t0s = last_hs[0];
        offer(0, 8'hFF);
        offer(0, 8'h00);
        tx_valid_v[0] = 1'b0;
        chk("b2b_hs_lat", 32'(last_hs[0] - t0s), 32'd126);
        idle_cycles(120);
        chk("b2b_rises", 32'(rises[0] - r0s), 32'd24);
        chk("b2b_bd", 32'(bdc[0] - b0s), 32'd3);
        chk("b2b_frames", 32'(falls[0] - f0s), 32'd1);
        chk("b2b_dec", 32'(dec_cnt[0] - d0s), 32'd3);
        chk("b2b_last", 32'(last_dec[0]), 32'h00);

        // Frame ends at the boundary; a valid raised during HOLD waits for IDLE.
        f0s = falls[0];
        offer(0, 8'h81);
        tx_valid_v[0] = 1'b0;
        t0s = last_hs[0];
        idle_cycles(64);
        offer(0, 8'h7E);
        tx_valid_v[0] = 1'b0;
        chk("gap_hs_lat", 32'(last_hs[0] - t0s), 32'd69);
        idle_cycles(90);
        chk("gap_frames", 32'(falls[0] - f0s), 32'd2);
        chk("gap_csn_high", 32'(hirun[0]), 32'd3);
        chk("gap_last", 32'(last_dec[0]), 32'h7E);

        // Fastest timing: SCLK at clk/2.
        r0s = rises[1]; b0s = bdc[1];
        offer(1, 8'h55);
        tx_valid_v[1] = 1'b0;
        t0s = last_hs[1];
        idle_cycles(40);
        chk("fast_bd_lat", 32'(last_bd[1] - t0s), 32'd17);
        chk("fast_rises", 32'(rises[1] - r0s), 32'd8);
        chk("fast_bd", 32'(bdc[1] - b0s), 32'd1);
        chk("fast_val", 32'(last_dec[1]), 32'h55);

        // Reset after the 4th rising edge of 0xF0.
        r0s = rises[0]; b0s = bdc[0]; d0s = dec_cnt[0];
        offer(0, 8'hF0);
        tx_valid_v[0] = 1'b0;
        got4 = 1'b0;
        for (int n = 0; n < 200 && !got4; n++) begin
            @(posedge clk);
            #1;
            if (rises[0] - r0s >= 4) got4 = 1'b1;
        end
        chk("rst_wait", 32'(got4), 32'd1);
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        @(negedge clk);
        chk("rst_csn", 32'(csn_w[0]), 32'd1);
        chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
        chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
        chk("rst_ready", 32'(rdy_w[0]), 32'd0);
        idle_cycles(80);
        chk("rst_bd", 32'(bdc[0] - b0s), 32'd0);
        chk("rst_dec", 32'(dec_cnt[0] - d0s), 32'd0);

        // Held valid while busy is only taken at the byte boundary.
        h0s = hs_cnt[0]; d0s = dec_cnt[0];
        offer(0, 8'hC3);
        t0s = last_hs[0];
        offer(0, 8'h12);
        tx_valid_v[0] = 1'b0;
        chk("stall_hs_lat", 32'(last_hs[0] - t0s), 32'd62);
        idle_cycles(100);
        chk("stall_hs", 32'(hs_cnt[0] - h0s), 32'd2);
        chk("stall_dec", 32'(dec_cnt[0] - d0s), 32'd2);
        chk("stall_last", 32'(last_dec[0]), 32'h12);

        // Random traffic on both instances.
        h0s = hs_cnt[0] + hs_cnt[1];
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                tx_valid_v[i] = ($urandom_range(0, 9) < 6);
                tx_data_v[i]  = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        tx_valid_v = 2'b00;
        idle_cycles(200);
        chk("rand_drain0", 32'(wp[0] - rp[0]), 32'd0);
        chk("rand_drain1", 32'(wp[1] - rp[1]), 32'd0);
        chk("rand_partial0", 32'(nb[0]), 32'd0);
        chk("rand_partial1", 32'(nb[1]), 32'd0);
        chk("rand_traffic", 32'(hs_cnt[0] + hs_cnt[1] - h0s > 40), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
